seq_divider_64: RTL and testbench

Multi-cycle 64-bit integer divider in the ALU execute path. It implements RISC-V DIV/DIVU/REM/REMU semantics using a restoring, one-bit-per-cycle algorithm. Each iteration's trial subtraction is done by an instance of the existing 64-bit ripple adder/subtracter (adder_64bit, b inverted, cin=1). The block sits directly downstream of operand issue and consumes the adder's sum/carry every cycle; quotient and remainder go to ALU result writeback.

---
 rtl/seq_divider_64_pkg.sv | 18 +
 rtl/adder_64bit.sv | 22 ++
 rtl/seq_divider_64.sv | 158 +++++++++++++++
 tb/tb_seq_divider_64.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_64_pkg.sv
// Shared definitions for the sequential 64-bit divider: width, state encoding, sign helper.
package seq_divider_64_pkg;

  localparam int unsigned WIDTH = 64;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_PREP = 2'd1;
  localparam state_t S_CALC = 2'd2;
  localparam state_t S_FIX  = 2'd3;

  // Two's complement negate, wrapping at WIDTH bits.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

endpackage

// File: rtl/adder_64bit.sv
// 64-bit ripple-carry adder; used as a subtracter by inverting b and setting cin.
module adder_64bit (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_cin,
  output logic [63:0] o_sum,
  output logic        o_cout
);

  logic w_c;

  always_comb begin
    w_c = i_cin;
    o_sum = '0;
    for (int i = 0; i < 64; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/seq_divider_64.sv
// Restoring one-bit-per-cycle divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Fixed 67-cycle latency from start acceptance to the done pulse.
module seq_divider_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import seq_divider_64_pkg::*;

  if (WIDTH != seq_divider_64_pkg::WIDTH) begin : g_width_chk
    $error("seq_divider_64: only WIDTH=64 is supported");
  end
  if ($clog2(WIDTH + 1) > CNT_W) begin : g_cnt_chk
    $error("seq_divider_64: CNT_W too small for WIDTH");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy, r_done, r_dz;
  logic [WIDTH-1:0] r_quot, r_rem_out;
  logic             r_signed, r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_a, r_b, r_bmag, r_q, r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic             w_busy_nxt, w_done_nxt, w_load, w_prep, w_step, w_fix;
  logic [WIDTH-1:0] w_shifted, w_bmag_n, w_sum;
  logic             w_cout, w_success;

  // Trial subtraction: shifted - |divisor|.
  assign w_shifted = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_bmag_n  = ~r_bmag;

  adder_64bit u_sub (
    .i_a    (w_shifted),
    .i_b    (w_bmag_n),
    .i_cin  (1'b1),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // rem[63] set means the shifted value is >= 2^64 and always exceeds the divisor.
  assign w_success = r_rem[WIDTH-1] | w_cout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_load     = 1'b0;
    w_prep     = 1'b0;
    w_step     = 1'b0;
    w_fix      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load     = start;
        w_busy_nxt = start;
      end
      S_PREP: begin
        w_prep     = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_CALC: begin
        w_step     = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_FIX: begin
        w_fix      = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_signed  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_bmag    <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_load) begin
        r_a      <= dividend;
        r_b      <= divisor;
        r_signed <= signed_op;
      end
      if (w_prep) begin
        r_q     <= (r_signed && r_a[WIDTH-1]) ? negate(r_a) : r_a;
        r_bmag  <= (r_signed && r_b[WIDTH-1]) ? negate(r_b) : r_b;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_neg_q <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_b != '0);
        r_neg_r <= r_signed & r_a[WIDTH-1];
      end
      if (w_step) begin
        r_rem <= w_success ? w_sum : w_shifted;
        r_q   <= {r_q[WIDTH-2:0], w_success};
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Divide by zero overrides the sign-corrected results.
      if (w_fix) begin
        if (r_b == '0) begin
          r_quot    <= '1;
          r_rem_out <= r_a;
          r_dz      <= 1'b1;
        end else begin
          r_quot    <= r_neg_q ? negate(r_q) : r_q;
          r_rem_out <= r_neg_r ? negate(r_rem) : r_rem;
          r_dz      <= 1'b0;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem_out;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider_64.sv
// Self-checking bench for seq_divider_64 against an arithmetic reference model.
module tb_seq_divider_64;

  logic        clk = 1'b0;
  logic        rst, start, signed_op;
  logic [63:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] prev_q = '0;
  logic [63:0] prev_r = '0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  seq_divider_64 dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // RISC-V division semantics from magnitudes and signs.
  function automatic void ref_div(input bit s, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output logic dz);
    logic [63:0] am, bm, qm, rm;
    if (b == 64'd0) begin
      q = ONES; r = a; dz = 1'b1;
    end else begin
      am = (s && a[63]) ? 64'd0 - a : a;
      bm = (s && b[63]) ? 64'd0 - b : b;
      qm = am / bm;
      rm = am % bm;
      q  = (s && (a[63] != b[63])) ? 64'd0 - qm : qm;
      r  = (s && a[63]) ? 64'd0 - rm : rm;
      dz = 1'b0;
    end
  endfunction

  // Issues one operation and returns in the done cycle (or after the cycle budget).
  task automatic run_op(input bit s, input logic [63:0] a, input logic [63:0] b,
                        input bit immediate, output int lat);
    if (!immediate) @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL busy_high: cycle %0d busy=%b expected 1", k, busy);
      end
      n_cmp++;
      if (quotient !== prev_q || remainder !== prev_r) begin
        n_err++;
        $display("FAIL hold: cycle %0d got q=%h r=%h expected q=%h r=%h", k, quotient, remainder, prev_q, prev_r);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (lat != 67) begin
      n_err++; $display("FAIL latency: got %0d expected 67", lat);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL busy_done: busy=%b expected 0", busy);
    end
  endtask

  task automatic check_op(input bit s, input logic [63:0] a, input logic [63:0] b,
                          input bit immediate, input string name);
    logic [63:0] eq, er;
    logic ez;
    int lat;
    ref_div(s, a, b, eq, er, ez);
    run_op(s, a, b, immediate, lat);
    n_cmp++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      n_err++;
      $display("FAIL %s: s=%0b a=%h b=%h got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
               name, s, a, b, quotient, remainder, div_by_zero, eq, er, ez);
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic check_pulse_end(input string name);
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || quotient !== prev_q || remainder !== prev_r) begin
      n_err++;
      $display("FAIL %s_pulse: done=%b q=%h r=%h expected done=0 q=%h r=%h",
               name, done, quotient, remainder, prev_q, prev_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 64'd0 || remainder !== 64'd0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h expected all 0", busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
    prev_q = '0; prev_r = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_directed();
    check_op(0, 64'd100, 64'd7, 0, "udiv_100_7");           check_pulse_end("udiv_100_7");
    check_op(1, 64'd0 - 64'd7, 64'd2, 0, "sdiv_m7_2");      check_pulse_end("sdiv_m7_2");
    check_op(0, 64'd5, 64'd0, 0, "udiv_by_zero");           check_pulse_end("udiv_by_zero");
    check_op(1, 64'd5, 64'd0, 0, "sdiv_by_zero");           check_pulse_end("sdiv_by_zero");
    check_op(1, 64'd0 - 64'd5, 64'd0, 0, "sdiv_neg_by_zero");
    check_op(1, MIN64, ONES, 0, "sdiv_overflow");           check_pulse_end("sdiv_overflow");
    check_op(0, ONES, ONES - 64'd1, 0, "udiv_rem63");       check_pulse_end("udiv_rem63");
    check_op(1, 64'd7, 64'd0 - 64'd2, 0, "sdiv_7_m2");
    check_op(1, 64'd0 - 64'd7, 64'd0 - 64'd2, 0, "sdiv_m7_m2");
    check_op(1, MIN64, 64'd1, 0, "sdiv_min_1");
    check_op(0, MIN64, 64'd3, 0, "udiv_min_3");
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    bit s;
    for (int i = 0; i < 25; i++) begin
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 63);
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) b = 64'd0;
      if ($urandom_range(0, 4) == 0) b = 64'd0 - ({32'd0, $urandom} >> $urandom_range(0, 31));
      check_op(s, a, b, 0, "random");
    end
    check_pulse_end("random");
  endtask

  task automatic test_start_ignored();
    logic [63:0] eq, er;
    logic ez;
    int n_done, first;
    ref_div(0, 64'd1000, 64'd33, eq, er, ez);
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 64'd1000; divisor = 64'd33;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; first = -1;
    for (int k = 1; k <= 150; k++) begin
      if (done) begin
        n_done++;
        if (first < 0) first = k;
      end
      start = (k == 10 || k == 40);
      dividend = 64'd77; divisor = 64'd5; signed_op = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (n_done != 1 || first != 67) begin
      n_err++; $display("FAIL start_ignored: dones=%0d first=%0d expected 1 at 67", n_done, first);
    end
    n_cmp++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      n_err++;
      $display("FAIL start_ignored_result: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, eq, er, ez);
    end
    prev_q = eq; prev_r = er;
  endtask

  task automatic test_reset_abort();
    int n_done;
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 64'd999; divisor = 64'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 64'd0 || remainder !== 64'd0) begin
      n_err++;
      $display("FAIL reset_abort: busy=%b done=%b dz=%b q=%h r=%h expected all 0", busy, done, div_by_zero, quotient, remainder);
    end
    prev_q = '0; prev_r = '0;
    n_done = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n_done != 0) begin
      n_err++; $display("FAIL reset_abort_done: got %0d dones expected 0", n_done);
    end
    check_op(1, 64'd0 - 64'd100, 64'd7, 0, "after_abort");
    check_pulse_end("after_abort");
  endtask

  task automatic test_back_to_back();
    check_op(0, 64'd123456789, 64'd1000, 0, "b2b_first");
    check_op(0, 64'd9, 64'd3, 1, "b2b_second");
    check_pulse_end("b2b_second");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
